dma_priority_resolver: RTL and testbench

DMA_PRIORITY_RESOLVER -- requirements
Module: dma_priority_resolver

---
 rtl/dma_pkg.sv | 27 ++
 rtl/dma_req_sync.sv | 21 ++
 rtl/dma_priority_resolver.sv | 122 ++++++++++++
 tb/tb_dma_priority_resolver.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA priority resolver.
// The picker scans from lowest to highest priority so the last hit is the winner.
package dma_pkg;

   typedef enum logic [1:0] {IDLE, HREQ, GRANT, RELEASE} dma_prio_state_t;

   localparam int NUM_CH_DEFAULT = 4;
   localparam int DMA_MAX_CH     = 8;

   // Highest-priority requesting channel, counting from top and wrapping at n.
   function automatic int unsigned dma_pick(input logic [DMA_MAX_CH-1:0] req,
                                            input int unsigned n,
                                            input int unsigned top);
      int unsigned win;
      int unsigned idx;
      win = 0;
      for (int k = DMA_MAX_CH - 1; k >= 0; k--) begin
         if (unsigned'(k) < n) begin
            idx = top + unsigned'(k);
            if (idx >= n) idx = idx - n;
            if (req[idx[2:0]]) win = idx;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/dma_req_sync.sv
// Per-bit request synchroniser, STAGES flops deep, clears to "no request".
// Latency STAGES cycles; no backpressure.
module dma_req_sync #(
   parameter int STAGES = 2
) (
   input  logic CLK,
   input  logic RESET,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) sync_q <= '0;
      else       sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dma_priority_resolver.sv
// DMA request arbiter with CPU hold handshake; optional rotating priority via DMA_ROT_PRIO_EN.
// Grant appears SYNC_STAGES+2 cycles after a raw request at the earliest; grant held until svcDone or hlda loss.
module dma_priority_resolver
   import dma_pkg::*;
#(
   parameter int NUM_CH      = NUM_CH_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic [NUM_CH-1:0]         dreq,
   input  logic                      dreqActiveLow,
   input  logic                      dackActiveHigh,
   input  logic [NUM_CH-1:0]         mask,
`ifdef DMA_ROT_PRIO_EN
   input  logic                      rotPrio,
`endif
   input  logic                      hlda,
   input  logic                      svcDone,
   output logic                      hrq,
   output logic [NUM_CH-1:0]         dack,
   output logic                      validDACK,
   output logic [$clog2(NUM_CH)-1:0] grantCh,
   output logic [NUM_CH-1:0]         validDreq
);

   localparam int CW = $clog2(NUM_CH);

   logic [NUM_CH-1:0] sync_dat;
   logic [NUM_CH-1:0] dack_onehot;
   dma_prio_state_t   state_q, state_d;
   logic [CW-1:0]     grant_q, grant_d;
   logic [CW-1:0]     winner, top_sel;
   logic              any_req;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
      dma_req_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .CLK   (CLK),
         .RESET (RESET),
         .d_i   (dreq[i] ^ dreqActiveLow),
         .q_o   (sync_dat[i])
      );
   end

   assign validDreq = sync_dat & ~mask;
   assign any_req   = |validDreq;

`ifdef DMA_ROT_PRIO_EN
   logic [CW-1:0] prio_top_q, prio_top_d;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) prio_top_q <= '0;
      else       prio_top_q <= prio_top_d;
   end

   assign top_sel = rotPrio ? prio_top_q : '0;
`else
   assign top_sel = '0;
`endif

   assign winner = CW'(dma_pick(DMA_MAX_CH'(validDreq), NUM_CH, 32'(top_sel)));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      hrq       = 1'b0;
      validDACK = 1'b0;
`ifdef DMA_ROT_PRIO_EN
      prio_top_d = prio_top_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) state_d = HREQ;
         end
         HREQ: begin
            hrq = 1'b1;
            if (hlda) begin
               if (any_req) begin
                  state_d = GRANT;
                  grant_d = winner;
               end else begin
                  state_d = RELEASE;
               end
            end else if (!any_req) begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            hrq       = 1'b1;
            validDACK = 1'b1;
            // Losing the bus wins over a simultaneous svcDone and leaves the pointer alone.
            if (!hlda) begin
               state_d = RELEASE;
            end else if (svcDone) begin
               state_d = RELEASE;
`ifdef DMA_ROT_PRIO_EN
               prio_top_d = (grant_q == CW'(NUM_CH - 1)) ? '0 : CW'(grant_q + 1'b1);
`endif
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign dack_onehot = validDACK ? (NUM_CH'(1) << grant_q) : '0;
   assign dack        = dackActiveHigh ? dack_onehot : ~dack_onehot;
   assign grantCh     = grant_q;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Directed and random checks of dma_priority_resolver against a cycle-level reference model.
module tb_dma_priority_resolver;

   localparam int SYNC = 2;
`ifdef DMA_ROT_PRIO_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [3:0] dreq = '0;
   logic [3:0] mask = '0;
   logic       dreqActiveLow = 1'b0;
   logic       dackActiveHigh = 1'b1;
   logic       rotPrio = 1'b0;
   logic       hlda = 1'b0;
   logic       svcDone = 1'b0;
   logic       hrq, validDACK;
   logic [3:0] dack, validDreq;
   logic [1:0] grantCh;

   logic [4:0] dreq_b = '0;
   logic       hlda_b = 1'b0;
   logic       svcDone_b = 1'b0;
   logic       hrq_b, validDACK_b;
   logic [4:0] dack_b, validDreq_b;
   logic [2:0] grantCh_b;

   int total = 0;
   int bad = 0;

   always #5 CLK = ~CLK;

   dma_priority_resolver #(.NUM_CH(4), .SYNC_STAGES(SYNC)) u_dut (
      .CLK(CLK), .RESET(RESET), .dreq(dreq), .dreqActiveLow(dreqActiveLow),
      .dackActiveHigh(dackActiveHigh), .mask(mask),
`ifdef DMA_ROT_PRIO_EN
      .rotPrio(rotPrio),
`endif
      .hlda(hlda), .svcDone(svcDone), .hrq(hrq), .dack(dack),
      .validDACK(validDACK), .grantCh(grantCh), .validDreq(validDreq)
   );

   dma_priority_resolver #(.NUM_CH(5), .SYNC_STAGES(SYNC)) u_dut5 (
      .CLK(CLK), .RESET(RESET), .dreq(dreq_b), .dreqActiveLow(1'b0),
      .dackActiveHigh(1'b1), .mask(5'b00000),
`ifdef DMA_ROT_PRIO_EN
      .rotPrio(rotPrio),
`endif
      .hlda(hlda_b), .svcDone(svcDone_b), .hrq(hrq_b), .dack(dack_b),
      .validDACK(validDACK_b), .grantCh(grantCh_b), .validDreq(validDreq_b)
   );

   // Reference model: phase 0 idle, 1 requesting hold, 2 granted, 3 release gap.
   logic [3:0] m_pipe [SYNC];
   int         m_phase, m_grant, m_top;

   function automatic int pick(input logic [3:0] v, input int top);
      for (int k = 0; k < 4; k++)
         if (v[(top + k) % 4]) return (top + k) % 4;
      return 0;
   endfunction

   always @(posedge CLK or posedge RESET) begin
      logic [3:0] v;
      if (RESET) begin
         m_phase = 0; m_grant = 0; m_top = 0;
         for (int i = 0; i < SYNC; i++) m_pipe[i] = '0;
      end else begin
         v = m_pipe[SYNC-1] & ~mask;
         case (m_phase)
            0: if (v != 0) m_phase = 1;
            1: if (hlda) begin
                  if (v != 0) begin
                     m_phase = 2;
                     m_grant = pick(v, (ROT_EN && rotPrio) ? m_top : 0);
                  end else m_phase = 3;
               end else if (v == 0) m_phase = 0;
            2: if (!hlda) m_phase = 3;
               else if (svcDone) begin
                  m_phase = 3;
                  if (ROT_EN) m_top = (m_grant + 1) % 4;
               end
            default: m_phase = 0;
         endcase
         for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
         m_pipe[0] = dreq ^ {4{dreqActiveLow}};
      end
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic [3:0] oh, e_dack, e_vd;
      logic       e_hrq, e_vld;
      logic [1:0] e_gnt;
      e_vld  = (m_phase == 2);
      e_hrq  = (m_phase == 1) || (m_phase == 2);
      oh     = e_vld ? (4'b0001 << m_grant) : 4'b0000;
      e_dack = dackActiveHigh ? oh : ~oh;
      e_vd   = m_pipe[SYNC-1] & ~mask;
      e_gnt  = m_grant[1:0];
      chk("m_hrq", {7'd0, hrq}, {7'd0, e_hrq});
      chk("m_validDACK", {7'd0, validDACK}, {7'd0, e_vld});
      chk("m_dack", {4'd0, dack}, {4'd0, e_dack});
      chk("m_grantCh", {6'd0, grantCh}, {6'd0, e_gnt});
      chk("m_validDreq", {4'd0, validDreq}, {4'd0, e_vd});
   endtask

   task automatic cyc();
      @(posedge CLK);
      #2;
      check_model();
   endtask

   task automatic do_reset();
      dreq = '0; mask = '0; dreqActiveLow = 1'b0; dackActiveHigh = 1'b1;
      hlda = 1'b0; svcDone = 1'b0; dreq_b = '0; hlda_b = 1'b0; svcDone_b = 1'b0;
      RESET = 1'b1;
      @(posedge CLK);
      #2;
      check_model();
      RESET = 1'b0;
   endtask

   int w;
   int exp_rot;

   initial begin
      // Reset state
      do_reset();
      chk("rst_hrq", {7'd0, hrq}, 8'd0);
      chk("rst_vld", {7'd0, validDACK}, 8'd0);
      chk("rst_gnt", {6'd0, grantCh}, 8'd0);
      chk("rst_dack", {4'd0, dack}, 8'd0);

      // Fixed priority: ch1 beats ch3, then ch3 after service
      rotPrio = 1'b0;
      dreq = 4'b1010;
      cyc(); cyc();
      chk("fx_hrq_early", {7'd0, hrq}, 8'd0);
      cyc();
      chk("fx_hrq", {7'd0, hrq}, 8'd1);
      hlda = 1'b1;
      cyc();
      chk("fx_gnt", {6'd0, grantCh}, 8'd1);
      chk("fx_dack", {4'd0, dack}, 8'b0010);
      chk("fx_vld", {7'd0, validDACK}, 8'd1);
      dreq = 4'b1000;
      cyc(); cyc();
      svcDone = 1'b1;
      cyc();
      svcDone = 1'b0;
      chk("fx_rel_hrq", {7'd0, hrq}, 8'd0);
      chk("fx_rel_dack", {4'd0, dack}, 8'd0);
      cyc(); cyc(); cyc();
      chk("fx_gnt3", {6'd0, grantCh}, 8'd3);
      chk("fx_dack3", {4'd0, dack}, 8'b1000);
      dreq = '0; svcDone = 1'b1; cyc(); svcDone = 1'b0; hlda = 1'b0;
      repeat (4) cyc();

      // Mask withdraws the request while waiting for hlda
      do_reset();
      dreq = 4'b0001;
      cyc(); cyc(); cyc();
      chk("mk_hrq", {7'd0, hrq}, 8'd1);
      mask = 4'b0001;
      cyc();
      chk("mk_idle_hrq", {7'd0, hrq}, 8'd0);
      chk("mk_dack", {4'd0, dack}, 8'd0);
      dreq = '0;
      repeat (3) begin
         cyc();
         chk("mk_no_vld", {7'd0, validDACK}, 8'd0);
      end
      mask = '0;

      // Abort: hlda drop in GRANT, ch2 regranted first
      do_reset();
      rotPrio = ROT_EN;
      dreq = 4'b1100; hlda = 1'b1;
      repeat (4) cyc();
      chk("ab_gnt", {6'd0, grantCh}, 8'd2);
      hlda = 1'b0;
      cyc();
      chk("ab_dack", {4'd0, dack}, 8'd0);
      chk("ab_vld", {7'd0, validDACK}, 8'd0);
      hlda = 1'b1;
      cyc(); cyc(); cyc();
      chk("ab_regnt", {6'd0, grantCh}, 8'd2);
      chk("ab_revld", {7'd0, validDACK}, 8'd1);
      dreq = '0; svcDone = 1'b1; cyc(); svcDone = 1'b0; hlda = 1'b0;
      repeat (4) cyc();

      // Polarity inversion on both sides
      do_reset();
      rotPrio = 1'b0;
      dreqActiveLow = 1'b1; dackActiveHigh = 1'b0; dreq = 4'b1111;
      repeat (3) cyc();
      chk("pol_idle_dack", {4'd0, dack}, 8'b1111);
      dreq = 4'b1110; hlda = 1'b1;
      repeat (4) cyc();
      chk("pol_gnt", {6'd0, grantCh}, 8'd0);
      chk("pol_dack", {4'd0, dack}, 8'b1110);
      dreq = 4'b1111; svcDone = 1'b1; cyc(); svcDone = 1'b0; hlda = 1'b0;
      repeat (4) cyc();

      // Asynchronous reset mid-GRANT, then hold-off after release
      do_reset();
      dreq = 4'b0100; hlda = 1'b1;
      repeat (4) cyc();
      chk("ar_pre_vld", {7'd0, validDACK}, 8'd1);
      @(posedge CLK);
      #3;
      RESET = 1'b1;
      #1;
      chk("ar_hrq", {7'd0, hrq}, 8'd0);
      chk("ar_vld", {7'd0, validDACK}, 8'd0);
      chk("ar_dack", {4'd0, dack}, 8'd0);
      check_model();
      @(posedge CLK);
      #2;
      RESET = 1'b0;
      cyc();
      chk("ar_hold1", {7'd0, hrq}, 8'd0);
      cyc();
      chk("ar_hold2", {7'd0, hrq}, 8'd0);
      cyc();
      chk("ar_hrq3", {7'd0, hrq}, 8'd1);
      dreq = '0; hlda = 1'b0;
      repeat (4) cyc();

      // Rotating order on the 5-channel instance, wrapping 4 -> 0
      do_reset();
      rotPrio = 1'b1;
      dreq_b = 5'b11111; hlda_b = 1'b1;
      for (int n = 0; n < 6; n++) begin
         w = 0;
         while (!validDACK_b && w < 20) begin
            cyc();
            w++;
         end
         exp_rot = ROT_EN ? (n % 5) : 0;
         chk("rot_wait", {7'd0, validDACK_b}, 8'd1);
         chk("rot_gnt", {5'd0, grantCh_b}, 8'(exp_rot));
         svcDone_b = 1'b1;
         cyc();
         svcDone_b = 1'b0;
      end
      dreq_b = '0; hlda_b = 1'b0;

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) dreq = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 11) == 0) mask = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 4) == 0) hlda = ~hlda;
         svcDone = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 39) == 0) dreqActiveLow = ~dreqActiveLow;
         if ($urandom_range(0, 39) == 0) dackActiveHigh = ~dackActiveHigh;
         if ($urandom_range(0, 49) == 0) rotPrio = ~rotPrio;
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
